// File: rtl/nios2e_dip_debounce_if.sv
// Switch-side bundle for the DIP debouncer: raw pins in, accepted levels and
// edge pulses out.
interface nios2e_dip_debounce_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] debounced_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any_change;

    modport master (
        output raw_in,
        input  debounced_out,
        input  rise,
        input  fall,
        input  any_change
    );

    modport slave (
        input  raw_in,
        output debounced_out,
        output rise,
        output fall,
        output any_change
    );
endinterface

// File: rtl/nios2e_dip_debounce.sv
// Per-bit two-flop synchronizer plus saturating stability counter for the board
// DIP switches; emits clean levels and one-cycle rise/fall/any-change pulses.
module nios2e_dip_debounce #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios2e_dip_debounce_if.slave  dip
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] debounced_q, debounced_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             any_change_q, any_change_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        sync1_d     = dip.raw_in;
        sync2_d     = sync1_q;
        debounced_d = debounced_q;
        rise_d      = '0;
        fall_d      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            // Any return to the accepted level restarts the stability count.
            if (sync2_q[i] == debounced_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                debounced_d[i] = sync2_q[i];
                cnt_d[i]       = '0;
                rise_d[i]      = sync2_q[i];
                fall_d[i]      = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        // Taken from next-state pulses so it lines up with the level flip.
        any_change_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            debounced_q  <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            any_change_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            debounced_q  <= debounced_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            any_change_q <= any_change_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign dip.debounced_out = debounced_q;
    assign dip.rise          = rise_q;
    assign dip.fall          = fall_q;
    assign dip.any_change    = any_change_q;
endmodule

// File: tb/tb_nios2e_dip_debounce.sv
// Directed bench for the DIP debouncer: one short-filter instance for the main
// scenarios and two long-filter instances running alongside for the 50000 case.
module tb_nios2e_dip_debounce;
    localparam int W  = 16;
    localparam int NS = 4;
    localparam int NL = 50000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0;
    logic rst_nl;

    nios2e_dip_debounce_if #(.WIDTH(W)) b0 ();
    nios2e_dip_debounce_if #(.WIDTH(W)) b1 ();
    nios2e_dip_debounce_if #(.WIDTH(W)) b2 ();

    nios2e_dip_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(NS)) u_short (
        .clk(clk), .reset_n(rst_n0), .dip(b0));
    nios2e_dip_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(NL)) u_long_pulse (
        .clk(clk), .reset_n(rst_nl), .dip(b1));
    nios2e_dip_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(NL)) u_long_hold (
        .clk(clk), .reset_n(rst_nl), .dip(b2));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: a level is accepted once the last N filter-visible samples (raw
    // captured two edges earlier) all disagree with the accepted level.
    int          nflt [3] = '{NS, NL, NL};
    int          t    [3];
    logic [W-1:0] hist [3][4];
    logic [W-1:0] acc  [3];
    logic [W-1:0] erise[3];
    logic [W-1:0] efall[3];
    int          last_ag [3][W];

    task automatic model_clear(input int j);
        t[j]     = 0;
        acc[j]   = '0;
        erise[j] = '0;
        efall[j] = '0;
        for (int i = 0; i < W; i++) last_ag[j][i] = 0;
        for (int k = 0; k < 4; k++) hist[j][k] = '0;
    endtask

    task automatic model_edge(input int j, input logic [W-1:0] r);
        logic [W-1:0] v;
        t[j] = t[j] + 1;
        hist[j][t[j] % 4] = r;
        v = (t[j] >= 3) ? hist[j][(t[j] - 2) % 4] : '0;
        erise[j] = '0;
        efall[j] = '0;
        for (int i = 0; i < W; i++) begin
            if (v[i] == acc[j][i]) begin
                last_ag[j][i] = t[j] - 2;
            end else if ((t[j] - 2) - last_ag[j][i] >= nflt[j]) begin
                acc[j][i]     = v[i];
                last_ag[j][i] = t[j] - 2;
                if (v[i]) erise[j][i] = 1'b1;
                else      efall[j][i] = 1'b1;
            end
        end
    endtask

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_inst(input int j, input logic [W-1:0] deb, input logic [W-1:0] ri,
                            input logic [W-1:0] fa, input logic any);
        check($sformatf("m%0d_deb", j),  deb, acc[j]);
        check($sformatf("m%0d_rise", j), ri,  erise[j]);
        check($sformatf("m%0d_fall", j), fa,  efall[j]);
        check($sformatf("m%0d_any", j),  {{(W-1){1'b0}}, any},
              {{(W-1){1'b0}}, |(erise[j] | efall[j])});
    endtask

    task automatic cmp_all();
        cmp_inst(0, b0.debounced_out, b0.rise, b0.fall, b0.any_change);
        cmp_inst(1, b1.debounced_out, b1.rise, b1.fall, b1.any_change);
        cmp_inst(2, b2.debounced_out, b2.rise, b2.fall, b2.any_change);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n0) model_clear(0); else model_edge(0, b0.raw_in);
        if (!rst_nl) begin
            model_clear(1);
            model_clear(2);
        end else begin
            model_edge(1, b1.raw_in);
            model_edge(2, b2.raw_in);
        end
        #1;
        cmp_all();
        cyc++;
        b1.raw_in = (cyc < NL - 1) ? 16'h0001 : 16'h0000;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        rst_n0    = 1'b0;
        rst_nl    = 1'b0;
        b0.raw_in = 16'hFFFF;
        b1.raw_in = 16'h0001;
        b2.raw_in = 16'h8001;
        for (int j = 0; j < 3; j++) model_clear(j);

        // Reset with all switches high
        settle(3);
        check("rst_deb",  b0.debounced_out, 16'h0000);
        check("rst_rise", b0.rise, 16'h0000);
        rst_n0 = 1'b1;
        rst_nl = 1'b1;
        cyc    = 0;
        b1.raw_in = 16'h0001;
        settle(5);
        check("t1_deb_e5", b0.debounced_out, 16'h0000);
        tick();
        check("t1_deb_e6",  b0.debounced_out, 16'hFFFF);
        check("t1_rise_e6", b0.rise, 16'hFFFF);
        check("t1_any_e6",  {15'd0, b0.any_change}, 16'h0001);
        tick();
        check("t1_rise_e7", b0.rise, 16'h0000);

        // Clean step on bit 0
        b0.raw_in = 16'h0000;
        settle(8);
        check("t2_base", b0.debounced_out, 16'h0000);
        b0.raw_in = 16'h0001;
        settle(5);
        check("t2_deb_e5", b0.debounced_out, 16'h0000);
        tick();
        check("t2_deb_e6",  b0.debounced_out, 16'h0001);
        check("t2_rise_e6", b0.rise, 16'h0001);
        tick();
        check("t2_rise_e7", b0.rise, 16'h0000);

        // Bounce on bit 3: 3 high, 1 low, 2 high, 1 low, then steady
        begin
            logic [6:0] pat;
            pat = 7'b0110111;
            for (int k = 0; k < 7; k++) begin
                b0.raw_in = {12'h000, pat[k], 3'b001};
                tick();
            end
        end
        check("t3_bounce", b0.debounced_out, 16'h0001);
        b0.raw_in = 16'h0009;
        settle(5);
        check("t3_deb_e5", b0.debounced_out, 16'h0001);
        tick();
        check("t3_deb_e6",  b0.debounced_out, 16'h0009);
        check("t3_rise_e6", b0.rise, 16'h0008);

        // Simultaneous flips in both directions
        b0.raw_in = 16'h00FF;
        settle(8);
        check("t4_base", b0.debounced_out, 16'h00FF);
        b0.raw_in = 16'hFF00;
        settle(6);
        check("t4_deb",  b0.debounced_out, 16'hFF00);
        check("t4_rise", b0.rise, 16'hFF00);
        check("t4_fall", b0.fall, 16'h00FF);
        check("t4_any",  {15'd0, b0.any_change}, 16'h0001);

        // Reset in the middle of a pending 0->1
        b0.raw_in = 16'h0000;
        settle(8);
        b0.raw_in = 16'h0001;
        settle(4);
        rst_n0 = 1'b0;
        model_clear(0);
        #1;
        cmp_all();
        check("t5_async_deb", b0.debounced_out, 16'h0000);
        settle(2);
        rst_n0 = 1'b1;
        settle(5);
        check("t5_deb_e5", b0.debounced_out, 16'h0000);
        tick();
        check("t5_deb_e6",  b0.debounced_out, 16'h0001);
        check("t5_rise_e6", b0.rise, 16'h0001);

        // Long filter: 49999-cycle pulse is rejected, steady hold lands at 50002
        while (cyc < NL + 1) tick();
        check("t6_hold_e50001", b2.debounced_out, 16'h0000);
        tick();
        check("t6_hold_e50002", b2.debounced_out, 16'h8001);
        check("t6_hold_rise",   b2.rise, 16'h8001);
        check("t6_pulse_e50002", b1.debounced_out, 16'h0000);
        settle(3);
        check("t6_pulse_after", b1.debounced_out, 16'h0000);
        check("t6_pulse_rise",  b1.rise, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
